// File: rtl/i2c_pkg.sv
// Shared types and constants for the single-byte I2C master.
// Read support is compiled in only when I2C_MASTER_READ_EN is defined.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    START,
    ADDR,
    ADDR_ACK,
    WDATA,
    WACK,
    RDATA,
    MACK,
    STOP,
    DONE
  } i2c_state_t;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  localparam int         I2C_DEFAULT_CLK_DIV    = 125;
  localparam logic [6:0] I2C_DEFAULT_SLAVE_ADDR = 7'b1010001;
  localparam logic [7:0] I2C_TEST_DATA          = 8'hAB;

endpackage

// File: rtl/i2c_master_fsm_if.sv
// Request/response and SCL/ownership signals between a requester and i2c_master_fsm.
// The open-drain style SDA line stays a plain inout port on the master.
interface i2c_master_fsm_if;

  // Handshake: start is a one-cycle request taken only while the master is idle
  // (busy=0); addr/rw/wdata are captured on that cycle, done pulses once at the end
  // with rdata/ack_err valid, and a start seen while busy is dropped, never queued.
  logic       start;
  logic [6:0] addr;
  logic       rw;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       busy;
  logic       done;
  logic       ack_err;
  logic       sclk;
  logic       sda_dir_m;

  modport master (
    input  start, addr, rw, wdata,
    output rdata, busy, done, ack_err, sclk, sda_dir_m
  );

  modport slave (
    output start, addr, rw, wdata,
    input  rdata, busy, done, ack_err, sclk, sda_dir_m
  );

endinterface

// File: rtl/i2c_qtick_gen.sv
// Quarter-period timebase: counts CLK_DIV cycles per SCL quarter and tracks the
// quarter index; held at zero while disabled so every phase starts aligned.
module i2c_qtick_gen
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = I2C_DEFAULT_CLK_DIV
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic       qtick,
  output logic [1:0] qidx
);

  localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

  logic [7:0] cnt;

  assign qtick = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt  <= '0;
      qidx <= Q0;
    end else if (cnt == LAST) begin
      cnt  <= '0;
      qidx <= qidx + 2'd1;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/i2c_master_fsm.sv
// Single-byte I2C master: START, address+R/W, ACK, one data byte, ACK/NACK, STOP.
// Define I2C_MASTER_READ_EN to build the read path (RDATA/MACK, rw honoured, rdata loaded).
module i2c_master_fsm
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = I2C_DEFAULT_CLK_DIV
) (
  input  logic              clk,
  input  logic              rst,
  i2c_master_fsm_if.master  bus,
  inout  wire               sda,
  output i2c_state_t        state
);

  logic       sda_o;
  logic       qtick;
  logic [1:0] qidx;
  logic       en;
  logic [7:0] shreg;
  logic [7:0] wbyte;
  logic [2:0] bit_idx;
  logic       ack_bit;

`ifdef I2C_MASTER_READ_EN
  logic       rw_r;
  logic [7:0] rx;
`else
  logic       rw_unused;
  assign rw_unused = bus.rw;
  assign bus.rdata = 8'h00;
`endif

  assign en  = (state != IDLE) && (state != DONE);
  assign sda = bus.sda_dir_m ? sda_o : 1'bz;

  i2c_qtick_gen #(.CLK_DIV(CLK_DIV)) u_qtick (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .qtick (qtick),
    .qidx  (qidx)
  );

  // Outputs for quarter k+1 are registered on the qtick that ends quarter k,
  // so SDA and ownership change exactly at the first cycle of q0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      bus.sclk      <= 1'b1;
      sda_o         <= 1'b1;
      bus.sda_dir_m <= 1'b1;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.ack_err   <= 1'b0;
      shreg         <= '0;
      wbyte         <= '0;
      bit_idx       <= '0;
      ack_bit       <= 1'b0;
`ifdef I2C_MASTER_READ_EN
      rw_r          <= 1'b0;
      rx            <= '0;
      bus.rdata     <= '0;
`endif
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state       <= START;
            bus.busy    <= 1'b1;
            bus.ack_err <= 1'b0;
            wbyte       <= bus.wdata;
`ifdef I2C_MASTER_READ_EN
            shreg       <= {bus.addr, bus.rw};
            rw_r        <= bus.rw;
`else
            shreg       <= {bus.addr, 1'b0};
`endif
          end
        end
        START: begin
          if (qtick) begin
            if (qidx == Q1) sda_o <= 1'b0;
            if (qidx == Q3) begin
              state    <= ADDR;
              bit_idx  <= 3'd7;
              bus.sclk <= 1'b0;
              sda_o    <= shreg[7];
              shreg    <= {shreg[6:0], 1'b0};
            end
          end
        end
        ADDR, WDATA: begin
          if (qtick) begin
            if (qidx == Q1) bus.sclk <= 1'b1;
            if (qidx == Q3) begin
              bus.sclk <= 1'b0;
              if (bit_idx == 3'd0) begin
                state         <= (state == ADDR) ? ADDR_ACK : WACK;
                bus.sda_dir_m <= 1'b0;
              end else begin
                bit_idx <= bit_idx - 3'd1;
                sda_o   <= shreg[7];
                shreg   <= {shreg[6:0], 1'b0};
              end
            end
          end
        end
        ADDR_ACK: begin
          if (qtick) begin
            if (qidx == Q1) bus.sclk <= 1'b1;
            if (qidx == Q2) ack_bit <= sda;
            if (qidx == Q3) begin
              bus.sclk      <= 1'b0;
              bus.sda_dir_m <= 1'b1;
              bit_idx       <= 3'd7;
              if (ack_bit) begin
                bus.ack_err <= 1'b1;
                state       <= STOP;
                sda_o       <= 1'b0;
              end else
`ifdef I2C_MASTER_READ_EN
              if (rw_r) begin
                state         <= RDATA;
                bus.sda_dir_m <= 1'b0;
              end else
`endif
              begin
                state <= WDATA;
                sda_o <= wbyte[7];
                shreg <= {wbyte[6:0], 1'b0};
              end
            end
          end
        end
        WACK: begin
          if (qtick) begin
            if (qidx == Q1) bus.sclk <= 1'b1;
            if (qidx == Q2) ack_bit <= sda;
            if (qidx == Q3) begin
              bus.sclk      <= 1'b0;
              bus.sda_dir_m <= 1'b1;
              bus.ack_err   <= bus.ack_err | ack_bit;
              sda_o         <= 1'b0;
              state         <= STOP;
            end
          end
        end
`ifdef I2C_MASTER_READ_EN
        RDATA: begin
          if (qtick) begin
            if (qidx == Q1) bus.sclk <= 1'b1;
            if (qidx == Q2) rx <= {rx[6:0], sda};
            if (qidx == Q3) begin
              bus.sclk <= 1'b0;
              if (bit_idx == 3'd0) begin
                state         <= MACK;
                bus.sda_dir_m <= 1'b1;
                sda_o         <= 1'b1;
              end else begin
                bit_idx <= bit_idx - 3'd1;
              end
            end
          end
        end
        MACK: begin
          if (qtick) begin
            if (qidx == Q1) bus.sclk <= 1'b1;
            if (qidx == Q3) begin
              bus.sclk  <= 1'b0;
              sda_o     <= 1'b0;
              bus.rdata <= rx;
              state     <= STOP;
            end
          end
        end
`endif
        STOP: begin
          if (qtick) begin
            if (qidx == Q0) bus.sclk <= 1'b1;
            if (qidx == Q1) sda_o <= 1'b1;
            if (qidx == Q3) begin
              state    <= DONE;
              bus.done <= 1'b1;
            end
          end
        end
        DONE: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_master_fsm.sv
// Bench for i2c_master_fsm: behavioural slave on the bus, per-transaction outcome model,
// directed cases from the test plan plus randomized transactions.
module tb_i2c_master_fsm;
  import i2c_pkg::*;

  localparam int CLK_DIV = 16;
  localparam int TIMEOUT = 100 * CLK_DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  wire        sda;
  logic       slave_sda = 1'b1;
  i2c_state_t state;

  i2c_master_fsm_if bus();

  i2c_master_fsm #(.CLK_DIV(CLK_DIV)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .sda   (sda),
    .state (state)
  );

  assign sda = bus.sda_dir_m ? 1'bz : slave_sda;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];
  logic [7:0] exp_rdata = 8'h00;
  int         done_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------- behavioural slave / bus monitor ----------------
  logic [7:0] cfg_rd_byte = 8'h00;
  logic       cfg_nack_data = 1'b0;
  logic       p_scl = 1'b1;
  logic       p_sda = 1'b1;
  logic       in_frame = 1'b0;
  logic       slave_rd = 1'b0;
  logic       mack_bit = 1'b0;
  logic [7:0] sh = 8'h00;
  int         fcnt = 0;

  always @(negedge clk) begin
    if (bus.done) done_cnt++;
    if (p_scl && bus.sclk && p_sda && !sda) begin
      in_frame  = 1'b1;
      fcnt      = 0;
      slave_sda = 1'b1;
    end else if (p_scl && bus.sclk && !p_sda && sda) begin
      in_frame = 1'b0;
    end else if (in_frame && p_scl && !bus.sclk) begin
      // falling SCL closes frame fcnt-1 and opens frame fcnt
      if (fcnt >= 1) begin
        sh = {sh[6:0], p_sda};
        if (fcnt - 1 == 7 || fcnt - 1 == 16) obs_q.push_back(sh);
        if (fcnt - 1 == 17) mack_bit = p_sda;
      end
      if (fcnt == 8) begin
        slave_rd  = sh[0];
        slave_sda = (sh[7:1] == I2C_DEFAULT_SLAVE_ADDR) ? 1'b0 : 1'b1;
      end else if (fcnt >= 9 && fcnt <= 16 && slave_rd) begin
        slave_sda = cfg_rd_byte[16 - fcnt];
      end else if (fcnt == 17 && !slave_rd) begin
        slave_sda = cfg_nack_data;
      end else begin
        slave_sda = 1'b1;
      end
      fcnt++;
    end
    p_scl = bus.sclk;
    p_sda = sda;
  end

  // ---------------- driver tasks ----------------
  task automatic run_txn(input logic [6:0] a, input logic r, input logic [7:0] wd,
                         input logic [7:0] rb, input logic nd, input bit poke_busy);
    logic r_eff;
    logic ack;
    logic exp_err;
    int   quarters;
    int   waited;
    bit   got_done;
`ifdef I2C_MASTER_READ_EN
    r_eff = r;
`else
    r_eff = 1'b0;
`endif
    ack      = (a == I2C_DEFAULT_SLAVE_ADDR);
    quarters = ack ? 80 : 44;
    exp_err  = !ack || (!r_eff && nd);
    exp_q.delete();
    obs_q.delete();
    exp_q.push_back({a, r_eff});
    if (ack) exp_q.push_back(r_eff ? rb : wd);
    if (ack && r_eff) exp_rdata = rb;
    cfg_rd_byte   = rb;
    cfg_nack_data = nd;
    done_cnt      = 0;
    mack_bit      = 1'b0;

    @(negedge clk);
    bus.start = 1'b1;
    bus.addr  = a;
    bus.rw    = r;
    bus.wdata = wd;
    @(negedge clk);
    bus.start = 1'b0;
    bus.addr  = 7'($urandom);
    bus.rw    = 1'($urandom);
    bus.wdata = 8'($urandom);
    check_eq("busy_after_accept", {31'd0, bus.busy}, 32'd1);

    waited   = 0;
    got_done = 0;
    while (!got_done && waited < TIMEOUT) begin
      if (poke_busy && waited == 10 * CLK_DIV) begin
        bus.start = 1'b1;
        bus.addr  = 7'h00;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      waited++;
      if (bus.done) got_done = 1;
    end
    bus.start = 1'b0;
    check_eq("done_seen", {31'd0, got_done}, 32'd1);
    if (got_done) begin
      check_eq("done_latency", waited, quarters * CLK_DIV);
      check_eq("ack_err", {31'd0, bus.ack_err}, {31'd0, exp_err});
      check_eq("rdata", {24'd0, bus.rdata}, {24'd0, exp_rdata});
      check_eq("busy_at_done", {31'd0, bus.busy}, 32'd1);
      @(negedge clk);
      check_eq("busy_after_done", {31'd0, bus.busy}, 32'd0);
      check_eq("state_idle", 32'(state), 32'(IDLE));
    end
    repeat (3) @(negedge clk);
    check_eq("done_count", done_cnt, 1);
    check_eq("byte_count", obs_q.size(), exp_q.size());
    foreach (exp_q[i])
      if (i < obs_q.size()) check_eq($sformatf("bus_byte%0d", i), {24'd0, obs_q[i]}, {24'd0, exp_q[i]});
    if (ack && r_eff) check_eq("mack_nack", {31'd0, mack_bit}, 32'd1);
  endtask

  task automatic reset_mid_write(input logic [7:0] wd);
    done_cnt = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.addr  = I2C_DEFAULT_SLAVE_ADDR;
    bus.rw    = 1'b0;
    bus.wdata = wd;
    @(negedge clk);
    bus.start = 1'b0;
    // WDATA bit 4 is frame 12, which opens at quarter 4 + 4*12
    repeat ((4 + 4 * 12) * CLK_DIV + 2 * CLK_DIV) @(negedge clk);
    check_eq("state_wdata", 32'(state), 32'(WDATA));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("rst_sclk", {31'd0, bus.sclk}, 32'd1);
    check_eq("rst_dir", {31'd0, bus.sda_dir_m}, 32'd1);
    check_eq("rst_sda", {31'd0, sda}, 32'd1);
    check_eq("rst_busy", {31'd0, bus.busy}, 32'd0);
    check_eq("rst_state", 32'(state), 32'(IDLE));
    in_frame  = 1'b0;
    slave_sda = 1'b1;
    exp_rdata = 8'h00;
    repeat (60 * CLK_DIV) @(negedge clk);
    check_eq("rst_no_done", done_cnt, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [6:0] ra;
    bus.start = 1'b0;
    bus.addr  = '0;
    bus.rw    = 1'b0;
    bus.wdata = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("reset_sclk", {31'd0, bus.sclk}, 32'd1);
    check_eq("reset_sda", {31'd0, sda}, 32'd1);
    check_eq("reset_dir", {31'd0, bus.sda_dir_m}, 32'd1);
    check_eq("reset_busy", {31'd0, bus.busy}, 32'd0);
    check_eq("reset_done", {31'd0, bus.done}, 32'd0);
    check_eq("reset_ack_err", {31'd0, bus.ack_err}, 32'd0);
    check_eq("reset_rdata", {24'd0, bus.rdata}, 32'd0);
    check_eq("reset_state", 32'(state), 32'(IDLE));
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_txn(7'h51, 1'b0, I2C_TEST_DATA, 8'h00, 1'b0, 1'b0);
    run_txn(7'h22, 1'b0, I2C_TEST_DATA, 8'h00, 1'b0, 1'b0);
    run_txn(7'h51, 1'b0, 8'h12, 8'h00, 1'b1, 1'b0);
    run_txn(7'h51, 1'b0, 8'h3C, 8'h00, 1'b0, 1'b1);
`ifdef I2C_MASTER_READ_EN
    run_txn(7'h51, 1'b1, 8'h00, 8'h5C, 1'b0, 1'b0);
`endif
    reset_mid_write(8'hC3);
    repeat (4) @(negedge clk);

    for (int t = 0; t < 12; t++) begin
      ra = ($urandom_range(0, 3) != 0) ? I2C_DEFAULT_SLAVE_ADDR : 7'($urandom_range(0, 127));
      run_txn(ra, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
              ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/i2c_master_fsm.md
# i2c_master_fsm

Single-byte I2C bus master that drives `sclk`, `sda` and `sda_dir_m` toward `i2c_slave_fsm`, its direct downstream consumer. On a `start` request it generates a START, shifts out a 7-bit address plus R/W bit, samples the slave ACK, transfers one data byte, samples or drives the data ACK, and issues a STOP. Completion and ACK failures are reported through `done` and `ack_err`.

## Interface
- `CLK_DIV`, 125: `clk` cycles per SCL quarter-period; legal values are 2..255. The SCL period is 4*CLK_DIV.
- `clk`  in  1  system clock; every register is on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `addr`  in  7  target address; captured on accept.
- `rw`  in  1  R/W bit; captured on accept; 1 = read.
- `wdata`  in  8  write byte; captured on accept.
- `rdata`  out  8  read byte; valid while `done` is high.
- `busy`  out  1  high from the cycle after accept through the `done` cycle.
- `done`  out  1  one-cycle pulse at the end of the transaction.
- `ack_err`  out  1  set at `done` if any expected slave ACK read back 1; held until the next accept.
- `sclk`  out  1  I2C clock.
- `sda`  inout  1  driven with `sda_o` when `sda_dir_m`=1, otherwise high-Z.
- `sda_dir_m`  out  1  1 = the master owns SDA; 0 = released to the slave.

## Operation
- Reset values: `sclk`=1, `sda_o`=1, `sda_dir_m`=1, `busy`=0, `done`=0, `ack_err`=0, `rdata`=0. The state is IDLE and the quarter counter is 0.
- States and transitions:
  - IDLE to START on `start`.
  - START (4 quarters) to ADDR.
  - ADDR (8 bit frames, bits {addr,rw} MSB first) to ADDR_ACK.
  - ADDR_ACK (1 frame, `sda_dir_m`=0): if the sampled bit is 1, set `ack_err` and go to STOP. Otherwise go to WDATA if `rw`=0, or to RDATA if `rw`=1 (macro only).
  - WDATA (8 frames, MSB first) to WACK.
  - WACK (1 frame, `sda_dir_m`=0): set `ack_err` if the sampled bit is 1, then go to STOP.
  - RDATA (8 frames, `sda_dir_m`=0, shift in MSB first) to MACK.
  - MACK (1 frame, master drives NACK, `sda_o`=1) to STOP.
  - STOP (4 quarters) to DONE.
  - DONE (1 cycle, `done`=1) to IDLE.
- START quarters: q0–q1 SDA=1, SCL=1; q2–q3 SDA=0, SCL=1.
- Bit frame quarters:
  - q0: SCL=0; SDA is updated on the first cycle of q0.
  - q1: SCL=0.
  - q2–q3: SCL=1.
  - SDA is sampled on the last cycle of q2. SDA is stable across both SCL edges.
- STOP quarters: q0 SCL=0, SDA=0; q1 SCL=1, SDA=0; q2–q3 SCL=1, SDA=1.
- `sda_dir_m` changes only at the first cycle of q0 of a frame, so ownership never switches while SCL is high.
- `start` while busy is ignored; no queuing.
- `rst` mid-transaction: the next edge forces the reset values. No STOP is generated and `done` does not pulse.

## Timing
- Accept: `start`=1 in IDLE at edge N gives `busy`=1 at N+1, and START q0 begins at N+1.
- Full write/read transaction: 80 quarters = 80*CLK_DIV cycles, plus the DONE cycle.
- Address NACK: 44 quarters (START + 9 frames + STOP), plus the DONE cycle.
- `busy` falls on the cycle after `done`.
- The quarter counter counts 0..CLK_DIV-1 and wraps; the quarter index counts 0..3 and wraps; the bit index counts 7..0.

## Configuration
- `I2C_MASTER_READ_EN` defined: RDATA and MACK are built; `rw` is honoured; `rdata` is loaded.
- `I2C_MASTER_READ_EN` undefined: the R/W bit is forced to 0, the `rw` input is ignored, and `rdata` is tied to 0. RDATA/MACK logic is absent.

## Structure
- Package `i2c_pkg` holds:
  - the state enum;
  - quarter index constants;
  - `I2C_DEFAULT_CLK_DIV`=125;
  - `I2C_DEFAULT_SLAVE_ADDR`=7'b1010001;
  - `I2C_TEST_DATA`=8'hAB.
- Sub-module `i2c_qtick_gen` is the quarter counter. It takes `clk`, `rst` and `en`, and outputs a `qtick` pulse and a 2-bit `qidx`.

## Test plan
- `addr`=7'h51, `rw`=0, `wdata`=8'hAB to an `i2c_slave_fsm` at default address:
  - bits captured on SCL falling edges are 8'hA2, then 8'hAB;
  - `done` arrives 10000 cycles after `busy` rises;
  - `ack_err`=0.
- `addr`=7'h22 with the same slave: ADDR_ACK samples 1, `ack_err`=1, STOP follows directly, and `done` arrives at 44*125 cycles.
- `addr`=7'h51, `wdata`=8'h12: the slave NACKs the data, giving `ack_err`=1 and `done` at 80*125 cycles.
- Pulse `start` again while busy with `addr`=7'h00: no effect, the bus waveform is unchanged, and only one `done` occurs.
- Assert `rst` during WDATA bit 4 for 1 cycle: the next cycle shows `sclk`=1, `sda_dir_m`=1, `sda`=1, `busy`=0, and no `done`.
- With `I2C_MASTER_READ_EN`, `rw`=1, and the slave model returning 8'h5C: `rdata`=8'h5C with `done`, MACK SDA=1, and `ack_err`=0.
